// File: rtl/dcache_wb_evict_pkg.sv
// Shared definitions for the write-back eviction engine: default line geometry,
// beat counts and the engine's FSM state type.
package cache_defs;

   localparam int NUM_COL           = 16;
   localparam int COL_WIDTH         = 8;
   localparam int DCACHE_NO_OF_SETS = 64;
   localparam int PADDR_WIDTH       = 32;
   localparam int MEM_DW            = 32;

   localparam int DCACHE_LINE_BITS  = NUM_COL * COL_WIDTH;
   localparam int DCACHE_WB_BEATS   = DCACHE_LINE_BITS / MEM_DW;
   localparam int DCACHE_WB_BEAT_W  = (DCACHE_WB_BEATS > 1) ? $clog2(DCACHE_WB_BEATS) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_BUS  = 3'd3,
      S_DONE = 3'd4
   } wb_evict_state_e;

endpackage

// File: rtl/dcache_wb_evict_line_buf.sv
// Victim line register for the eviction engine; presents one MEM_DW beat of the
// captured line, selected by the current beat index.
module dcache_wb_line_buf #(
   parameter int LINE_BITS = 128,
   parameter int MEM_DW    = 32,
   parameter int BEAT_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cap_i,
   input  logic [LINE_BITS-1:0] line_i,
   input  logic [BEAT_W-1:0]    beat_i,
   output logic [MEM_DW-1:0]    dat_o
);

   logic [LINE_BITS-1:0] line_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q <= '0;
      end else if (cap_i) begin
         line_q <= line_i;
      end
   end

   // Beat 0 is the least-significant word of the line.
   assign dat_o = line_q[int'(beat_i) * MEM_DW +: MEM_DW];

endmodule

// File: rtl/dcache_wb_evict.sv
// Dirty-line eviction engine: reads a victim line from the dcache data RAM and
// writes it out as a Wishbone classic burst. Optional ack timeout: DCACHE_WB_TIMEOUT_EN.
module dcache_wb_evict
   import cache_defs::*;
#(
   parameter int NUM_COL     = cache_defs::NUM_COL,
   parameter int COL_WIDTH   = cache_defs::COL_WIDTH,
   parameter int ADDR_WIDTH  = $clog2(cache_defs::DCACHE_NO_OF_SETS),
   parameter int PADDR_WIDTH = cache_defs::PADDR_WIDTH,
   parameter int MEM_DW      = cache_defs::MEM_DW,
   parameter int TIMEOUT_CYC = 255,
   localparam int LINE_BITS  = NUM_COL * COL_WIDTH,
   localparam int OFF_W      = $clog2(NUM_COL),
   localparam int TAG_W      = PADDR_WIDTH - ADDR_WIDTH - OFF_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   evict_req_i,
   input  logic [ADDR_WIDTH-1:0]  evict_set_i,
   input  logic [TAG_W-1:0]       evict_tag_i,
   output logic                   evict_ready_o,
   output logic                   evict_done_o,
   output logic                   evict_err_o,
   output logic                   ram_req_o,
   output logic [NUM_COL-1:0]     ram_wr_en_o,
   output logic [ADDR_WIDTH-1:0]  ram_addr_o,
   input  logic [LINE_BITS-1:0]   ram_rdata_i,
   output logic                   wb_cyc_o,
   output logic                   wb_stb_o,
   output logic                   wb_we_o,
   output logic [PADDR_WIDTH-1:0] wb_adr_o,
   output logic [MEM_DW-1:0]      wb_dat_o,
   output logic [MEM_DW/8-1:0]    wb_sel_o,
   input  logic                   wb_ack_i
);

   localparam int BEATS   = LINE_BITS / MEM_DW;
   localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BYTE_SH = $clog2(MEM_DW / 8);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   wb_evict_state_e        state_q, state_d;
   logic [ADDR_WIDTH-1:0]  set_q, set_d;
   logic [TAG_W-1:0]       tag_q, tag_d;
   logic [BEAT_W-1:0]      beat_q, beat_d;
   logic                   err_q, err_d;
   logic                   cap;
   logic [MEM_DW-1:0]      buf_dat;
   logic [OFF_W-1:0]       beat_off;

`ifdef DCACHE_WB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         set_q   <= '0;
         tag_q   <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
`ifdef DCACHE_WB_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         set_q   <= set_d;
         tag_q   <= tag_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
`ifdef DCACHE_WB_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   // Byte offset of the current beat within the line; never reaches the set field.
   assign beat_off = OFF_W'(beat_q) << BYTE_SH;

   always_comb begin
      state_d       = state_q;
      set_d         = set_q;
      tag_d         = tag_q;
      beat_d        = beat_q;
      err_d         = err_q;
`ifdef DCACHE_WB_TIMEOUT_EN
      tmo_d         = tmo_q;
`endif
      cap           = 1'b0;
      evict_ready_o = 1'b0;
      evict_done_o  = 1'b0;
      evict_err_o   = 1'b0;
      ram_req_o     = 1'b0;
      ram_addr_o    = '0;
      wb_cyc_o      = 1'b0;
      wb_stb_o      = 1'b0;
      wb_we_o       = 1'b0;
      wb_adr_o      = '0;
      wb_sel_o      = '0;
      case (state_q)
         S_IDLE: begin
            evict_ready_o = 1'b1;
            if (evict_req_i) begin
               set_d   = evict_set_i;
               tag_d   = evict_tag_i;
               err_d   = 1'b0;
               state_d = S_RD;
            end
         end
         S_RD: begin
            ram_req_o  = 1'b1;
            ram_addr_o = set_q;
            state_d    = S_CAP;
         end
         S_CAP: begin
            cap     = 1'b1;
            beat_d  = '0;
`ifdef DCACHE_WB_TIMEOUT_EN
            tmo_d   = '0;
`endif
            state_d = S_BUS;
         end
         S_BUS: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_we_o  = 1'b1;
            wb_sel_o = '1;
            wb_adr_o = {tag_q, set_q, beat_off};
            if (wb_ack_i) begin
`ifdef DCACHE_WB_TIMEOUT_EN
               tmo_d = '0;
`endif
               if (beat_q == LAST_BEAT) begin
                  state_d = S_DONE;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
`ifdef DCACHE_WB_TIMEOUT_EN
            else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
`endif
         end
         S_DONE: begin
            evict_done_o = 1'b1;
`ifdef DCACHE_WB_TIMEOUT_EN
            evict_err_o  = err_q;
`endif
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ram_wr_en_o = '0;
   assign wb_dat_o    = wb_cyc_o ? buf_dat : '0;

   dcache_wb_line_buf #(
      .LINE_BITS (LINE_BITS),
      .MEM_DW    (MEM_DW),
      .BEAT_W    (BEAT_W)
   ) u_line_buf (
      .clk    (clk),
      .rst_n  (rst_n),
      .cap_i  (cap),
      .line_i (ram_rdata_i),
      .beat_i (beat_q),
      .dat_o  (buf_dat)
   );

endmodule

// File: tb/tb_dcache_wb_evict.sv
// Directed bench for dcache_wb_evict: reset, zero-wait burst, ack stall, busy
// request handling, mid-burst reset and missing-ack behaviour.
module tb_dcache_wb_evict;
   import cache_defs::*;

   localparam int AW = 6;
   localparam int TW = 22;
   localparam int LB = 128;
   localparam logic [LB-1:0] LINE_A = 128'h33333333_22222222_11111111_00000000;
   localparam logic [31:0]   BASE_A = 32'h068A_CC50;  // tag 0x1A2B3, set 0x05
   localparam logic [31:0]   BASE_B = 32'h068A_CEA0;  // tag 0x1A2B3, set 0x2A

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          evict_req_i = 1'b0;
   logic [AW-1:0] evict_set_i = '0;
   logic [TW-1:0] evict_tag_i = '0;
   logic          evict_ready_o, evict_done_o, evict_err_o, ram_req_o;
   logic [15:0]   ram_wr_en_o;
   logic [AW-1:0] ram_addr_o;
   logic [LB-1:0] ram_rdata_i = '0;
   logic [LB-1:0] ram_line = '0;
   logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
   logic [31:0]   wb_adr_o, wb_dat_o;
   logic [3:0]    wb_sel_o;
   logic          ack_en = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (ram_req_o) ram_rdata_i <= ram_line;
   assign wb_ack_i = wb_stb_o & ack_en;

   dcache_wb_evict dut (
      .clk(clk), .rst_n(rst_n),
      .evict_req_i(evict_req_i), .evict_set_i(evict_set_i), .evict_tag_i(evict_tag_i),
      .evict_ready_o(evict_ready_o), .evict_done_o(evict_done_o), .evict_err_o(evict_err_o),
      .ram_req_o(ram_req_o), .ram_wr_en_o(ram_wr_en_o), .ram_addr_o(ram_addr_o),
      .ram_rdata_i(ram_rdata_i),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i)
   );

   // Drives a request at the current negedge (cycle 0 of the scenario).
   task automatic raise_req(input logic [AW-1:0] s, input logic [TW-1:0] t);
      evict_req_i = 1'b1;
      evict_set_i = s;
      evict_tag_i = t;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({evict_ready_o, evict_done_o, evict_err_o, ram_req_o, wb_cyc_o, wb_stb_o} !== 6'b100000) begin
         n_bad++; $display("FAIL reset_ctl got %b want 100000",
            {evict_ready_o, evict_done_o, evict_err_o, ram_req_o, wb_cyc_o, wb_stb_o});
      end
      n_cmp++;
      if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || wb_sel_o !== 4'h0 || ram_wr_en_o !== 16'h0) begin
         n_bad++; $display("FAIL reset_data adr %h dat %h sel %h wr %h want all 0",
            wb_adr_o, wb_dat_o, wb_sel_o, ram_wr_en_o);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_zero_wait();
      int done_c = -1;
      ram_line = LINE_A;
      ack_en = 1'b1;
      raise_req(6'h05, 22'h1A2B3);
      n_cmp++;
      if (evict_ready_o !== 1'b1) begin n_bad++; $display("FAIL zw_ready got %b want 1", evict_ready_o); end
      for (int c = 1; c <= 20 && done_c < 0; c++) begin
         @(negedge clk);
         evict_req_i = 1'b0;
         n_cmp++;
         if (ram_wr_en_o !== 16'h0) begin n_bad++; $display("FAIL zw_wren c%0d got %h want 0", c, ram_wr_en_o); end
         n_cmp++;
         if (ram_req_o !== (c == 1)) begin n_bad++; $display("FAIL zw_ramreq c%0d got %b want %b", c, ram_req_o, c == 1); end
         if (c == 1) begin
            n_cmp++;
            if (ram_addr_o !== 6'h05) begin n_bad++; $display("FAIL zw_ramaddr got %h want 05", ram_addr_o); end
         end
         if (c >= 3 && c <= 6) begin
            n_cmp++;
            if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b111_1111) begin
               n_bad++; $display("FAIL zw_ctl c%0d got %b want 1111111", c, {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o});
            end
            n_cmp++;
            if (wb_adr_o !== BASE_A + 32'(4 * (c - 3))) begin
               n_bad++; $display("FAIL zw_adr c%0d got %h want %h", c, wb_adr_o, BASE_A + 32'(4 * (c - 3)));
            end
            n_cmp++;
            if (wb_dat_o !== 32'(c - 3) * 32'h11111111) begin
               n_bad++; $display("FAIL zw_dat c%0d got %h want %h", c, wb_dat_o, 32'(c - 3) * 32'h11111111);
            end
         end
         if (evict_done_o) done_c = c;
      end
      n_cmp++;
      if (done_c !== 7) begin n_bad++; $display("FAIL zw_done_cycle got %0d want 7", done_c); end
      n_cmp++;
      if (evict_err_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
         n_bad++; $display("FAIL zw_done_state err %b cyc %b want 0 0", evict_err_o, wb_cyc_o);
      end
      @(negedge clk);
      n_cmp++;
      if (evict_ready_o !== 1'b1 || evict_done_o !== 1'b0) begin
         n_bad++; $display("FAIL zw_after ready %b done %b want 1 0", evict_ready_o, evict_done_o);
      end
   endtask

   task automatic test_ack_stall();
      int done_c = -1;
      int exp_b;
      ram_line = LINE_A;
      raise_req(6'h05, 22'h1A2B3);
      for (int c = 1; c <= 30 && done_c < 0; c++) begin
         @(negedge clk);
         evict_req_i = 1'b0;
         ack_en = !(c >= 4 && c <= 6);
         exp_b = (c == 3) ? 0 : (c <= 7) ? 1 : c - 6;
         if (c >= 3 && c <= 9) begin
            n_cmp++;
            if (wb_stb_o !== 1'b1 || wb_adr_o !== BASE_A + 32'(4 * exp_b) || wb_dat_o !== 32'(exp_b) * 32'h11111111) begin
               n_bad++; $display("FAIL stall_beat c%0d stb %b adr %h dat %h want 1 %h %h", c, wb_stb_o, wb_adr_o,
                  wb_dat_o, BASE_A + 32'(4 * exp_b), 32'(exp_b) * 32'h11111111);
            end
         end
         if (evict_done_o) done_c = c;
      end
      ack_en = 1'b1;
      n_cmp++;
      if (done_c !== 10) begin n_bad++; $display("FAIL stall_done_cycle got %0d want 10", done_c); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int done_c = -1;
      ram_line = LINE_A;
      // Part 1: one-cycle pulse during BUS is dropped.
      raise_req(6'h05, 22'h1A2B3);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         evict_req_i = (c == 4);
         evict_set_i = (c == 4) ? 6'h2A : 6'h05;
         if (c == 4) begin
            n_cmp++;
            if (evict_ready_o !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_ready got %b want 0", evict_ready_o); end
         end
         if (c == 8 || c == 9) begin
            n_cmp++;
            if (evict_ready_o !== 1'b1 || ram_req_o !== 1'b0) begin
               n_bad++; $display("FAIL b2b_ignored c%0d ready %b ramreq %b want 1 0", c, evict_ready_o, ram_req_o);
            end
         end
      end
      evict_req_i = 1'b0;
      // Part 2: request held from BUS onward is taken in the first IDLE cycle.
      raise_req(6'h05, 22'h1A2B3);
      for (int c = 1; c <= 30 && done_c < 0; c++) begin
         @(negedge clk);
         if (c == 1) evict_req_i = 1'b0;
         if (c == 4) raise_req(6'h2A, 22'h1A2B3);
         if (c == 9) evict_req_i = 1'b0;
         if (c == 8) begin
            n_cmp++;
            if (evict_ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_ready got %b want 1", evict_ready_o); end
         end
         if (c == 9) begin
            n_cmp++;
            if (ram_req_o !== 1'b1 || ram_addr_o !== 6'h2A) begin
               n_bad++; $display("FAIL b2b_accept ramreq %b addr %h want 1 2a", ram_req_o, ram_addr_o);
            end
         end
         if (c == 11 || c == 14) begin
            n_cmp++;
            if (wb_adr_o !== BASE_B + 32'(4 * (c - 11))) begin
               n_bad++; $display("FAIL b2b_adr c%0d got %h want %h", c, wb_adr_o, BASE_B + 32'(4 * (c - 11)));
            end
         end
         if (evict_done_o && c > 8) done_c = c;
      end
      n_cmp++;
      if (done_c !== 15) begin n_bad++; $display("FAIL b2b_done_cycle got %0d want 15", done_c); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_bus();
      ram_line = LINE_A;
      raise_req(6'h05, 22'h1A2B3);
      repeat (5) begin
         @(negedge clk);
         evict_req_i = 1'b0;
      end
      n_cmp++;
      if (wb_adr_o !== BASE_A + 32'd8) begin n_bad++; $display("FAIL rst_beat2 adr got %h want %h", wb_adr_o, BASE_A + 32'd8); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({wb_cyc_o, wb_stb_o, evict_done_o} !== 3'b000) begin
         n_bad++; $display("FAIL rst_async got %b want 000", {wb_cyc_o, wb_stb_o, evict_done_o});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({evict_ready_o, wb_cyc_o, evict_done_o} !== 3'b100) begin
            n_bad++; $display("FAIL rst_after c%0d got %b want 100", c, {evict_ready_o, wb_cyc_o, evict_done_o});
         end
      end
   endtask

   task automatic test_no_ack();
      int done_c = -1;
      logic err_at_done = 1'b0;
      ram_line = LINE_A;
      ack_en = 1'b0;
      raise_req(6'h05, 22'h1A2B3);
      for (int c = 1; c <= 300 && done_c < 0; c++) begin
         @(negedge clk);
         evict_req_i = 1'b0;
         if (c == 257) begin
            n_cmp++;
            if (wb_cyc_o !== 1'b1) begin n_bad++; $display("FAIL noack_cyc257 got %b want 1", wb_cyc_o); end
         end
         if (evict_done_o) begin
            done_c = c;
            err_at_done = evict_err_o;
         end
      end
`ifdef DCACHE_WB_TIMEOUT_EN
      n_cmp++;
      if (done_c !== 258 || err_at_done !== 1'b1) begin
         n_bad++; $display("FAIL noack_timeout done_cycle %0d err %b want 258 1", done_c, err_at_done);
      end
`else
      n_cmp++;
      if (done_c !== -1 || err_at_done !== 1'b0) begin
         n_bad++; $display("FAIL noack_wait done_cycle %0d err %b want -1 0", done_c, err_at_done);
      end
      n_cmp++;
      if (wb_cyc_o !== 1'b1 || wb_adr_o !== BASE_A) begin
         n_bad++; $display("FAIL noack_hold cyc %b adr %h want 1 %h", wb_cyc_o, wb_adr_o, BASE_A);
      end
`endif
      ack_en = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_ack_stall();
      test_back_to_back();
      test_reset_mid_bus();
      test_no_ack();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
